// File: rtl/soc_mux_wb_arb_if.sv
// Wishbone bundle seen by the N-master to 1-slave multiplexer.
// Master-side vectors are packed per master (master i at slice i).
// The "slave" modport is the multiplexer's view of the bundle.
// The "master" modport is the view of the environment that drives it.
interface soc_mux_wb_arb_if #(
  parameter int MASTERS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  // master side
  logic [MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [MASTERS*DATA_WIDTH-1:0] m_dat_i;
  logic [MASTERS-1:0]            m_cyc_i;
  logic [MASTERS-1:0]            m_stb_i;
  logic [MASTERS-1:0]            m_we_i;
  logic [MASTERS*SEL_WIDTH-1:0]  m_sel_i;
  logic [MASTERS*3-1:0]          m_cti_i;
  logic [MASTERS*2-1:0]          m_bte_i;
  logic [MASTERS*DATA_WIDTH-1:0] m_dat_o;
  logic [MASTERS-1:0]            m_ack_o;
  logic [MASTERS-1:0]            m_err_o;
  logic [MASTERS-1:0]            m_rty_o;

  // slave side
  logic [ADDR_WIDTH-1:0]         s_adr_o;
  logic [DATA_WIDTH-1:0]         s_dat_o;
  logic [SEL_WIDTH-1:0]          s_sel_o;
  logic                          s_we_o;
  logic [2:0]                    s_cti_o;
  logic [1:0]                    s_bte_o;
  logic                          s_cyc_o;
  logic                          s_stb_o;
  logic [DATA_WIDTH-1:0]         s_dat_i;
  logic                          s_ack_i;
  logic                          s_err_i;
  logic                          s_rty_i;

  modport slave (
    input  m_adr_i, m_dat_i, m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_cti_i, m_bte_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_cti_i, m_bte_i,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o
  );
endinterface

// File: rtl/soc_mux_wb_arb.sv
// Registered N-master to 1-slave Wishbone multiplexer.
// Arbitration: round-robin (ARB_MODE=0) or fixed priority, lowest index first (ARB_MODE=1).
// bus_hold freezes the bus once no master owns it.
// Optional response watchdog, enabled by defining SOC_MUX_WB_TIMEOUT_EN.
module soc_mux_wb_arb #(
  parameter int MASTERS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ARB_MODE   = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  soc_mux_wb_arb_if.slave    bus,
  input  logic               bus_hold,
  output logic               bus_hold_ack,
  output logic [MASTERS-1:0] grant_o
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int OWN_W     = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, OWN, HELD} state_t;

  state_t             state_reg, state_next;
  logic [OWN_W-1:0]   owner_reg, owner_next;
  logic [OWN_W-1:0]   rr_reg, rr_next;      // first index searched in round-robin mode
  logic [OWN_W-1:0]   winner;
  logic               found;
  logic               sel_cyc;              // owner is still running its cycle
  logic               fire;                 // watchdog timeout this cycle
  logic [MASTERS-1:0] owner_hot;

  // Pick the arbitration winner among requesting masters.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < MASTERS; k++) begin
      if (ARB_MODE == 0) begin
        idx = int'(rr_reg) + k;
        if (idx >= MASTERS) idx = idx - MASTERS;
      end else begin
        idx = k;
      end
      if (!found && bus.m_cyc_i[idx]) begin
        found  = 1'b1;
        winner = OWN_W'(idx);
      end
    end
  end

  // Next state: hold beats requests in IDLE; the owner's cyc drop costs one IDLE cycle.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    rr_next    = rr_reg;
    case (state_reg)
      IDLE: begin
        if (bus_hold) begin
          state_next = HELD;
        end else if (found) begin
          state_next = OWN;
          owner_next = winner;
          rr_next    = (int'(winner) == MASTERS - 1) ? '0 : winner + 1'b1;
        end
      end
      OWN:     if (!bus.m_cyc_i[owner_reg]) state_next = IDLE;
      HELD:    if (!bus_hold) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      rr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      rr_reg    <= rr_next;
    end
  end

  assign sel_cyc      = (state_reg == OWN) && bus.m_cyc_i[owner_reg];
  assign bus_hold_ack = (state_reg == HELD);

`ifdef SOC_MUX_WB_TIMEOUT_EN
  logic [15:0] wd_reg, wd_next;

  assign fire = sel_cyc && (wd_reg == 16'(TIMEOUT));

  // Count stalled strobe cycles; any response, low stb or a timeout restarts the count.
  always_comb begin
    wd_next = '0;
    if (sel_cyc && !fire && bus.m_stb_i[owner_reg] &&
        !(bus.s_ack_i || bus.s_err_i || bus.s_rty_i))
      wd_next = wd_reg + 16'd1;
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wd_reg <= '0;
    else         wd_reg <= wd_next;
  end
`else
  logic unused_timeout;
  assign fire           = 1'b0;
  assign unused_timeout = ^(16'(TIMEOUT));
`endif

  // Route the owner's request onto the slave bus; everything is 0 when nobody drives it.
  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_cti_o = '0;
    bus.s_bte_o = '0;
    if (sel_cyc) begin
      bus.s_cyc_o = 1'b1;
      bus.s_stb_o = bus.m_stb_i[owner_reg] & ~fire;
      bus.s_we_o  = bus.m_we_i[owner_reg];
      bus.s_adr_o = bus.m_adr_i[int'(owner_reg)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.s_dat_o = bus.m_dat_i[int'(owner_reg)*DATA_WIDTH +: DATA_WIDTH];
      bus.s_sel_o = bus.m_sel_i[int'(owner_reg)*SEL_WIDTH +: SEL_WIDTH];
      bus.s_cti_o = bus.m_cti_i[int'(owner_reg)*3 +: 3];
      bus.s_bte_o = bus.m_bte_i[int'(owner_reg)*2 +: 2];
    end
  end

  // Responses go to the active owner only; read data is broadcast.
  for (genvar gi = 0; gi < MASTERS; gi++) begin : g_master
    assign owner_hot[gi]   = (owner_reg == OWN_W'(gi));
    assign grant_o[gi]     = (state_reg == OWN) && owner_hot[gi];
    assign bus.m_ack_o[gi] = sel_cyc && owner_hot[gi] && bus.s_ack_i;
    assign bus.m_err_o[gi] = sel_cyc && owner_hot[gi] && (bus.s_err_i || fire);
    assign bus.m_rty_o[gi] = sel_cyc && owner_hot[gi] && bus.s_rty_i;
    assign bus.m_dat_o[gi*DATA_WIDTH +: DATA_WIDTH] = rst_ni ? bus.s_dat_i : '0;
  end
endmodule
